axi_master_sequencer: RTL and testbench
=======================================

# axi_master_sequencer

Sequences one bridge command at a time onto the AXI4-Lite master port of the UART-AXI4 bridge. It checks each command with the `Address_Aligner` sub-module and rejects illegal commands without bus activity. Legal commands become a single AXI4-Lite write or read, with byte-lane alignment of the data and a timeout. It sits between the frame parser (command side) and the AXI4-Lite interconnect, and returns one response per command to the frame builder.

## Interface
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent waiting in any AXI handshake state before aborting (≥2).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` / `cmd_ready` in / out, 1 each: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address.
- `cmd_size` in 2: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved.
- `cmd_wdata` in 32: write data, right-justified (LSB = first byte).
- `rsp_valid` / `rsp_ready` out / in, 1 each: response handshake.
- `rsp_status` out 8: 0x00 OK, 0x02 CMD_INV, 0x03 ADDR_ALIGN, 0x04 BUS_ERR, 0x05 TIMEOUT.
- `rsp_rdata` out 32: read data, right-justified and zero-extended; 0 for writes and errors.
- AXI4-Lite master signals:
  - `m_axi_awaddr` 32, `m_axi_awvalid` / `m_axi_awready`.
  - `m_axi_wdata` 32, `m_axi_wstrb` 4, `m_axi_wvalid` / `m_axi_wready`.
  - `m_axi_bresp` 2, `m_axi_bvalid` / `m_axi_bready`.
  - `m_axi_araddr` 32, `m_axi_arvalid` / `m_axi_arready`.
  - `m_axi_rdata` 32, `m_axi_rresp` 2, `m_axi_rvalid` / `m_axi_rready`.
  - `m_axi_awprot` / `m_axi_arprot` 3, tied to 3'b000.

## Operation
- **States:** IDLE, CHECK, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- **IDLE:** `cmd_ready` = 1. A `cmd_valid && cmd_ready` cycle registers write, addr, size and wdata, then moves to CHECK.
- **CHECK:** the aligner is driven from the registered fields.
  - `addr_ok` = 0: `rsp_status` = zero-extended aligner `status_code` (0x02 or 0x03), go to RESP. No AXI valid is ever asserted.
  - `addr_ok` = 1: go to WR_AW_W if write, RD_AR if read.
- **WR_AW_W:**
  - `awvalid` and `wvalid` both assert on entry.
  - `awaddr` = {addr[31:2], 2'b00}.
  - `wstrb` = aligner wstrb.
  - `wdata` = wdata << (8·addr[1:0]).
  - Each valid drops the cycle after its own ready. The two channels complete independently in either order or together; the state moves to WR_B once both are done.
- **WR_B:** `bready` = 1. On `bvalid`, status = 0x00 if `bresp[1]` = 0 (OKAY/EXOKAY), else 0x04. Go to RESP.
- **RD_AR:** `arvalid` = 1, `araddr` = {addr[31:2], 2'b00}. On `arready`, go to RD_R.
- **RD_R:**
  - `rready` = 1. On `rvalid`, rdata = (`rdata` >> 8·addr[1:0]), masked to 8/16/32 bits by size.
  - status = 0x00 if `rresp[1]` = 0, else 0x04, and rdata forced to 0. Go to RESP.
- **Timeout:**
  - The counter clears on entry to WR_AW_W or RD_AR. It increments every cycle spent in WR_AW_W, WR_B, RD_AR or RD_R without completing.
  - When it reaches TIMEOUT_CYCLES: all AXI valid/ready outputs drop, status = 0x05, rdata = 0, go to RESP.
  - This is a documented AXI abort; late responses from the slave are ignored.
- **RESP:** `rsp_valid` = 1 with stable status and rdata until `rsp_ready`, then return to IDLE.

## Timing
- **Reset:** state IDLE. All outputs are 0 during the reset cycle. `cmd_ready` rises the first cycle after `rst` deasserts.
- **Mid-operation reset:** every AXI valid/ready and `rsp_valid` are 0 on the next edge, and the command is discarded.
- **Rejected command:** accept at cycle N, CHECK at N+1, `rsp_valid` at N+2.
- **Legal write:** `awvalid`/`wvalid` first high at N+2. Zero-wait slave (ready at N+2, `bvalid` at N+3) gives `rsp_valid` at N+4.
- **Legal read:** `arvalid` at N+2. With `arready` at N+2 and `rvalid` at N+3, `rsp_valid` is at N+4.
- **Throughput:** `cmd_ready` is 0 from N+1 until the cycle after the response handshake. At most one outstanding transaction exists.
- **Registered outputs:** all AXI outputs are registered, and no combinational path exists from any AXI ready to any AXI valid.
- **Timeout boundary:** a ready/valid arriving in the same cycle the counter hits TIMEOUT_CYCLES wins, and the transaction completes normally.

## Structure
- **Shared package `uart_axi_pkg`:**
  - status code localparams (0x00, 0x02, 0x03, 0x04, 0x05), shared with the frame builder;
  - sequencer state enum;
  - AXI resp encodings.
- **Sub-module:** one instance of the existing `Address_Aligner` (combinational). No other sub-modules.

## Test plan
- **16-bit write:** write, addr 0x1000_0002, size 01, wdata 0x0000_ABCD, zero-wait slave → awaddr 0x1000_0000, wstrb 1100, wdata 0xABCD_0000, rsp status 0x00 at N+4.
- **Rejected commands:**
  - read, addr 0x0000_0003, size 10 → status 0x03, rdata 0, `rsp_valid` at N+2, no AXI valid ever asserted.
  - size 11 → status 0x02, no AXI valid ever asserted.
- **8-bit read:** read, addr 0x2000_0001, size 00, slave rdata 0x1122_3344 → rsp_rdata 0x0000_0033.
- **Split write handshake:** `wready` 3 cycles before `awready`, then bresp 2'b10 → wvalid drops after its ready, awvalid holds until its ready, status 0x04.
- **Timeout:** slave never asserts `arready`, TIMEOUT_CYCLES = 16 → arvalid drops after 16 cycles in RD_AR, status 0x05.
- **Back-pressure and reset:**
  - `rsp_ready` held low 5 cycles → response stable, `cmd_ready` low throughout.
  - `rst` asserted during WR_B → all outputs 0 next edge, then IDLE.

Source files
------------

// File: rtl/uart_axi_pkg.sv
// Shared definitions for the UART-AXI4 bridge: response status codes,
// AXI4-Lite response encodings and the sequencer state encoding.
package uart_axi_pkg;

  // Response status codes, shared with the frame builder
  localparam logic [7:0] STATUS_OK         = 8'h00;
  localparam logic [7:0] STATUS_CMD_INV    = 8'h02;
  localparam logic [7:0] STATUS_ADDR_ALIGN = 8'h03;
  localparam logic [7:0] STATUS_BUS_ERR    = 8'h04;
  localparam logic [7:0] STATUS_TIMEOUT    = 8'h05;

  // AXI4 response encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Sequencer states, fixed encodings kept from the legacy design
  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_CHECK   = 3'd1,
    SEQ_WR_AW_W = 3'd2,
    SEQ_WR_B    = 3'd3,
    SEQ_RD_AR   = 3'd4,
    SEQ_RD_R    = 3'd5,
    SEQ_RESP    = 3'd6
  } seq_state_e;

  // SLVERR and DECERR are errors; OKAY and EXOKAY are success
  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_master_sequencer_if.sv
// AXI4-Lite bus bundle between the sequencer (master) and the interconnect (slave).
interface axi_master_sequencer_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_master_sequencer_aligner.sv
// Address_Aligner: combinational legality check of size/address and
// generation of the byte-lane write strobe.
module Address_Aligner
  import uart_axi_pkg::*;
(
  input  logic [1:0] addr_lsb_i,
  input  logic [1:0] size_i,
  output logic       addr_ok_o,
  output logic [1:0] status_code_o,
  output logic [3:0] wstrb_o
);

  // Size decode, natural-alignment check and strobe placement
  always_comb begin
    addr_ok_o     = 1'b1;
    status_code_o = STATUS_OK[1:0];
    wstrb_o       = '0;
    case (size_i)
      2'b00: wstrb_o = 4'b0001 << addr_lsb_i;
      2'b01: begin
        wstrb_o = 4'b0011 << addr_lsb_i;
        if (addr_lsb_i[0]) begin
          addr_ok_o     = 1'b0;
          status_code_o = STATUS_ADDR_ALIGN[1:0];
        end
      end
      2'b10: begin
        wstrb_o = 4'b1111;
        if (addr_lsb_i != 2'b00) begin
          addr_ok_o     = 1'b0;
          status_code_o = STATUS_ADDR_ALIGN[1:0];
        end
      end
      default: begin
        addr_ok_o     = 1'b0;
        status_code_o = STATUS_CMD_INV[1:0];
      end
    endcase
  end

endmodule

// File: rtl/axi_master_sequencer.sv
// axi_master_sequencer: turns one bridge command at a time into a single
// AXI4-Lite write or read, with alignment checking and a handshake timeout.
module axi_master_sequencer
  import uart_axi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [31:0]                   cmd_addr,
  input  logic [1:0]                    cmd_size,
  input  logic [31:0]                   cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [7:0]                    rsp_status,
  output logic [31:0]                   rsp_rdata,
  axi_master_sequencer_if.master        m_axi
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] axi_wdata_q, axi_wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] araddr_q, araddr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_status_q, rsp_status_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic        aln_ok;
  logic [1:0]  aln_status;
  logic [3:0]  aln_wstrb;

  logic        aw_fire, w_fire, tmo_tick;
  logic [31:0] rd_shifted, rd_mask;

  Address_Aligner u_aligner (
    .addr_lsb_i   (addr_q[1:0]),
    .size_i       (size_q),
    .addr_ok_o    (aln_ok),
    .status_code_o(aln_status),
    .wstrb_o      (aln_wstrb)
  );

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = '0;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = axi_wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = '0;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  // Next-state logic: command capture, AXI channel sequencing, timeout abort
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    axi_wdata_d  = axi_wdata_q;
    wstrb_d      = wstrb_q;
    araddr_d     = araddr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;
    tmo_d        = tmo_q;
    aw_fire      = awvalid_q & m_axi.awready;
    w_fire       = wvalid_q & m_axi.wready;
    tmo_tick     = 1'b0;
    rd_shifted   = m_axi.rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   rd_mask = 32'h0000_00FF;
      2'b01:   rd_mask = 32'h0000_FFFF;
      default: rd_mask = '1;
    endcase

    case (state_q)
      SEQ_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          size_d      = cmd_size;
          wdata_d     = cmd_wdata;
          cmd_ready_d = 1'b0;
          state_d     = SEQ_CHECK;
        end
      end
      SEQ_CHECK: begin
        if (!aln_ok) begin
          rsp_status_d = {6'b0, aln_status};
          rsp_rdata_d  = '0;
          rsp_valid_d  = 1'b1;
          state_d      = SEQ_RESP;
        end else if (write_q) begin
          tmo_d       = '0;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          awaddr_d    = {addr_q[31:2], 2'b00};
          axi_wdata_d = wdata_q << {addr_q[1:0], 3'b000};
          wstrb_d     = aln_wstrb;
          state_d     = SEQ_WR_AW_W;
        end else begin
          tmo_d     = '0;
          arvalid_d = 1'b1;
          araddr_d  = {addr_q[31:2], 2'b00};
          state_d   = SEQ_RD_AR;
        end
      end
      SEQ_WR_AW_W: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          bready_d = 1'b1;
          state_d  = SEQ_WR_B;
        end else begin
          tmo_tick = 1'b1;
        end
      end
      SEQ_WR_B: begin
        if (m_axi.bvalid) begin
          bready_d     = 1'b0;
          rsp_status_d = axi_resp_is_err(m_axi.bresp) ? STATUS_BUS_ERR : STATUS_OK;
          rsp_rdata_d  = '0;
          rsp_valid_d  = 1'b1;
          state_d      = SEQ_RESP;
        end else begin
          tmo_tick = 1'b1;
        end
      end
      SEQ_RD_AR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = SEQ_RD_R;
        end else begin
          tmo_tick = 1'b1;
        end
      end
      SEQ_RD_R: begin
        if (m_axi.rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = SEQ_RESP;
          if (axi_resp_is_err(m_axi.rresp)) begin
            rsp_status_d = STATUS_BUS_ERR;
            rsp_rdata_d  = '0;
          end else begin
            rsp_status_d = STATUS_OK;
            rsp_rdata_d  = rd_shifted & rd_mask;
          end
        end else begin
          tmo_tick = 1'b1;
        end
      end
      SEQ_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // A handshake completing in the boundary cycle takes the normal path
    // above, so tmo_tick is only raised when nothing completed this cycle.
    if (tmo_tick) begin
      if (tmo_q == TMO_LAST) begin
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        rsp_status_d = STATUS_TIMEOUT;
        rsp_rdata_d  = '0;
        rsp_valid_d  = 1'b1;
        state_d      = SEQ_RESP;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEQ_IDLE;
      cmd_ready_q  <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      axi_wdata_q  <= '0;
      wstrb_q      <= '0;
      araddr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_rdata_q  <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      axi_wdata_q  <= axi_wdata_d;
      wstrb_q      <= wstrb_d;
      araddr_q     <= araddr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      tmo_q        <= tmo_d;
    end
  end

endmodule

// File: tb/tb_axi_master_sequencer.sv
// Directed bench for axi_master_sequencer with hand-computed expectations.
module tb_axi_master_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_status;
  logic [31:0] rsp_rdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned valid_cycles = 0;

  axi_master_sequencer_if axi ();

  axi_master_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_status(rsp_status),
    .rsp_rdata (rsp_rdata),
    .m_axi     (axi.master)
  );

  always #5 clk = ~clk;

  // Count every cycle in which any AXI request valid is high
  always @(posedge clk) begin
    if (axi.awvalid || axi.wvalid || axi.arvalid) valid_cycles <= valid_cycles + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle (handshake cycle N); returns in N+1
  task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
    check_vec("cmd_ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_size  = sz;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    check_vec("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_vec("rsp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
    check_vec("cmd_ready_after_rsp", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned snap;
    int unsigned ar_cycles;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;

    // Reset
    tick(); tick();
    check_vec("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check_vec("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_vec("rst_valids", {29'b0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
    rst = 1'b0;
    tick();
    check_vec("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);

    // 16-bit write, zero-wait slave
    issue_cmd(1'b1, 32'h1000_0002, 2'b01, 32'h0000_ABCD);
    check_vec("wr16_no_valid_in_check", {31'b0, axi.awvalid}, 32'd0);
    tick();
    check_vec("wr16_awvalid", {30'b0, axi.awvalid, axi.wvalid}, 32'd3);
    check_vec("wr16_awaddr", axi.awaddr, 32'h1000_0000);
    check_vec("wr16_wstrb", {28'b0, axi.wstrb}, 32'hC);
    check_vec("wr16_wdata", axi.wdata, 32'hABCD_0000);
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0;
    check_vec("wr16_valids_drop", {30'b0, axi.awvalid, axi.wvalid}, 32'd0);
    check_vec("wr16_bready", {31'b0, axi.bready}, 32'd1);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    tick();
    axi.bvalid = 1'b0;
    check_vec("wr16_rsp_valid_n4", {31'b0, rsp_valid}, 32'd1);
    check_vec("wr16_status", {24'b0, rsp_status}, 32'h00);
    check_vec("wr16_rdata", rsp_rdata, 32'h0);
    finish_rsp();

    // Rejected: misaligned 32-bit read
    snap = valid_cycles;
    issue_cmd(1'b0, 32'h0000_0003, 2'b10, 32'h0);
    check_vec("rej_align_no_rsp_n1", {31'b0, rsp_valid}, 32'd0);
    tick();
    check_vec("rej_align_rsp_valid_n2", {31'b0, rsp_valid}, 32'd1);
    check_vec("rej_align_status", {24'b0, rsp_status}, 32'h03);
    check_vec("rej_align_rdata", rsp_rdata, 32'h0);
    finish_rsp();
    check_vec("rej_align_no_axi", valid_cycles - snap, 32'd0);

    // Rejected: reserved size
    snap = valid_cycles;
    issue_cmd(1'b1, 32'h0000_0000, 2'b11, 32'h1234_5678);
    tick();
    check_vec("rej_size_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check_vec("rej_size_status", {24'b0, rsp_status}, 32'h02);
    finish_rsp();
    check_vec("rej_size_no_axi", valid_cycles - snap, 32'd0);

    // 8-bit read, then response back-pressure
    issue_cmd(1'b0, 32'h2000_0001, 2'b00, 32'h0);
    tick();
    check_vec("rd8_arvalid", {31'b0, axi.arvalid}, 32'd1);
    check_vec("rd8_araddr", axi.araddr, 32'h2000_0000);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    check_vec("rd8_arvalid_drop", {31'b0, axi.arvalid}, 32'd0);
    check_vec("rd8_rready", {31'b0, axi.rready}, 32'd1);
    axi.rvalid = 1'b1; axi.rdata = 32'h1122_3344; axi.rresp = 2'b00;
    tick();
    axi.rvalid = 1'b0; axi.rdata = '0;
    check_vec("rd8_rsp_valid_n4", {31'b0, rsp_valid}, 32'd1);
    check_vec("rd8_rdata", rsp_rdata, 32'h0000_0033);
    check_vec("rd8_status", {24'b0, rsp_status}, 32'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check_vec("bp_rdata_stable", rsp_rdata, 32'h0000_0033);
      check_vec("bp_status_stable", {24'b0, rsp_status}, 32'h00);
      check_vec("bp_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
    end
    finish_rsp();

    // Split write handshake: wready three cycles before awready, then SLVERR
    issue_cmd(1'b1, 32'h3000_0004, 2'b10, 32'hDEAD_BEEF);
    tick();
    check_vec("split_wstrb", {28'b0, axi.wstrb}, 32'hF);
    check_vec("split_wdata", axi.wdata, 32'hDEAD_BEEF);
    axi.wready = 1'b1;
    tick();
    axi.wready = 1'b0;
    check_vec("split_wvalid_drop", {31'b0, axi.wvalid}, 32'd0);
    check_vec("split_awvalid_hold1", {31'b0, axi.awvalid}, 32'd1);
    tick();
    check_vec("split_awvalid_hold2", {31'b0, axi.awvalid}, 32'd1);
    tick();
    check_vec("split_awvalid_hold3", {31'b0, axi.awvalid}, 32'd1);
    check_vec("split_no_bready_yet", {31'b0, axi.bready}, 32'd0);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    check_vec("split_awvalid_drop", {31'b0, axi.awvalid}, 32'd0);
    check_vec("split_bready", {31'b0, axi.bready}, 32'd1);
    axi.bvalid = 1'b1; axi.bresp = 2'b10;
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    check_vec("split_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check_vec("split_status", {24'b0, rsp_status}, 32'h04);
    finish_rsp();

    // Timeout: arready never arrives
    issue_cmd(1'b0, 32'h4000_0000, 2'b10, 32'h0);
    tick();
    ar_cycles = 0;
    for (int i = 0; i < 40 && axi.arvalid; i++) begin
      ar_cycles++;
      tick();
    end
    check_vec("tmo_arvalid_cycles", ar_cycles, 32'd16);
    check_vec("tmo_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check_vec("tmo_status", {24'b0, rsp_status}, 32'h05);
    check_vec("tmo_rdata", rsp_rdata, 32'h0);
    finish_rsp();

    // Timeout boundary: arready on the 16th RD_AR cycle and rvalid right after win
    issue_cmd(1'b0, 32'h5000_0002, 2'b01, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check_vec("bnd_arvalid_last", {31'b0, axi.arvalid}, 32'd1);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    check_vec("bnd_rready", {31'b0, axi.rready}, 32'd1);
    check_vec("bnd_no_rsp", {31'b0, rsp_valid}, 32'd0);
    axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_1234; axi.rresp = 2'b00;
    tick();
    axi.rvalid = 1'b0; axi.rdata = '0;
    check_vec("bnd_status", {24'b0, rsp_status}, 32'h00);
    check_vec("bnd_rdata", rsp_rdata, 32'h0000_CAFE);
    finish_rsp();

    // Reset during WR_B
    issue_cmd(1'b1, 32'h6000_0000, 2'b10, 32'h0000_0001);
    tick();
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0;
    check_vec("mrst_in_wr_b", {31'b0, axi.bready}, 32'd1);
    rst = 1'b1;
    tick();
    check_vec("mrst_bready", {31'b0, axi.bready}, 32'd0);
    check_vec("mrst_valids", {29'b0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
    check_vec("mrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_vec("mrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b0;
    axi.bvalid = 1'b1;
    tick();
    axi.bvalid = 1'b0;
    check_vec("mrst_idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_vec("mrst_late_b_ignored", {31'b0, rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
